// File: rtl/mem_func.sv
// Shared memory-access definitions: store/load function codes, access size helper,
// arbiter FSM state encoding and requester port IDs.
package mem_func;

  localparam logic [1:0] SB = 2'd0;
  localparam logic [1:0] SH = 2'd1;
  localparam logic [1:0] SW = 2'd2;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Access size in bytes; 0 marks an unknown function code.
  function automatic logic [2:0] size_of(input logic we, input logic [1:0] func_in,
                                         input logic [2:0] func_out);
    logic [2:0] size;
    size = 3'd0;
    if (we) begin
      case (func_in)
        SB:      size = 3'd1;
        SH:      size = 3'd2;
        SW:      size = 3'd4;
        default: size = 3'd0;
      endcase
    end else begin
      case (func_out)
        LB, LBU: size = 3'd1;
        LH, LHU: size = 3'd2;
        LW:      size = 3'd4;
        default: size = 3'd0;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise LS has fixed priority.
module mem_arb_pick
  import mem_func::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic last_grant,
  output logic winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (if_req && ls_req) begin
      winner = ~last_grant;
    end else if (ls_req) begin
      winner = PORT_LS;
    end else begin
      winner = PORT_IF;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = last_grant ^ if_req;
  assign winner      = ls_req ? PORT_LS : PORT_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data memory between fetch and load/store ports, one access per 3 cycles.
// Arbitration mode set by MEM_ARB_ROUND_ROBIN_EN (defined: round-robin, else LS priority).
module mem_arbiter
  import mem_func::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_func_in,
  input  logic [2:0]  ls_func_out,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic        ls_err,
  output logic [31:0] ls_rdata,
  output logic        mem_we,
  output logic [1:0]  mem_func_in,
  output logic [2:0]  mem_func_out,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  state_t      state_reg, state_next;
  logic        grant;
  logic        winner;
  logic        last_grant;
  logic        cmd_port_reg, cmd_we_reg, cmd_err_reg;
  logic [1:0]  cmd_func_in_reg;
  logic [2:0]  cmd_func_out_reg;
  logic [31:0] cmd_addr_reg, cmd_wdata_reg, rdata_reg;
  logic        req_we, req_err;
  logic [1:0]  req_func_in;
  logic [2:0]  req_func_out, req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [32:0] req_end;

  mem_arb_pick u_pick (
    .if_req    (if_req),
    .ls_req    (ls_req),
    .last_grant(last_grant),
    .winner    (winner)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_reg <= PORT_IF;
    end else if (grant) begin
      last_grant_reg <= winner;
    end
  end
  assign last_grant = last_grant_reg;
`else
  assign last_grant = PORT_IF;
`endif

  // Winner's payload and error check; the end address uses 33 bits so wrap-around is caught.
  always_comb begin
    if (winner == PORT_LS) begin
      req_we       = ls_we;
      req_func_in  = ls_func_in;
      req_func_out = ls_func_out;
      req_addr     = ls_addr;
      req_wdata    = ls_wdata;
    end else begin
      req_we       = 1'b0;
      req_func_in  = SB;
      req_func_out = LW;
      req_addr     = if_addr;
      req_wdata    = '0;
    end
    req_size = size_of(req_we, req_func_in, req_func_out);
    req_end  = {1'b0, req_addr} + {30'd0, req_size};
    req_err  = (req_size == 3'd0)
            || ((req_size == 3'd2) && req_addr[0])
            || ((req_size == 3'd4) && (req_addr[1:0] != 2'b00))
            || (req_end > 33'(MEM_BYTES));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      cmd_port_reg     <= PORT_IF;
      cmd_we_reg       <= 1'b0;
      cmd_err_reg      <= 1'b0;
      cmd_func_in_reg  <= '0;
      cmd_func_out_reg <= '0;
      cmd_addr_reg     <= '0;
      cmd_wdata_reg    <= '0;
      rdata_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        cmd_port_reg     <= winner;
        cmd_we_reg       <= req_we;
        cmd_err_reg      <= req_err;
        cmd_func_in_reg  <= req_func_in;
        cmd_func_out_reg <= req_func_out;
        cmd_addr_reg     <= req_addr;
        cmd_wdata_reg    <= req_wdata;
      end
      if (state_reg == ACCESS) begin
        rdata_reg <= mem_data_out;
      end
    end
  end

  assign resp_rdata = (cmd_we_reg || cmd_err_reg) ? 32'd0 : rdata_reg;

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    mem_we     = 1'b0;
    if_ack     = 1'b0;
    if_err     = 1'b0;
    if_rdata   = '0;
    ls_ack     = 1'b0;
    ls_err     = 1'b0;
    ls_rdata   = '0;
    case (state_reg)
      IDLE: begin
        if (if_req || ls_req) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_we     = cmd_we_reg & ~cmd_err_reg;
        state_next = RESP;
      end
      RESP: begin
        if (cmd_port_reg == PORT_LS) begin
          ls_ack   = 1'b1;
          ls_err   = cmd_err_reg;
          ls_rdata = resp_rdata;
        end else begin
          if_ack   = 1'b1;
          if_err   = cmd_err_reg;
          if_rdata = resp_rdata;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy         = (state_reg != IDLE);
  assign mem_func_in  = cmd_func_in_reg;
  assign mem_func_out = cmd_func_out_reg;
  assign mem_address  = cmd_addr_reg;
  assign mem_data_in  = cmd_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a byte-array memory model.
// Expectations for simultaneous requests follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic        clock, reset;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ack, ls_err;
  logic [1:0]  ls_func_in;
  logic [2:0]  ls_func_out;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_we, busy;
  logic [1:0]  mem_func_in;
  logic [2:0]  mem_func_out;
  logic [31:0] mem_address, mem_data_in, mem_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.MEM_BYTES(1024)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_func_in(ls_func_in), .ls_func_out(ls_func_out),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .mem_we(mem_we), .mem_func_in(mem_func_in), .mem_func_out(mem_func_out),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: little-endian bytes, combinational extending read, write on clock edge.
  logic [7:0] mem [0:1023];

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] fo);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a[9:0]];
    b1 = mem[a[9:0] + 10'd1];
    b2 = mem[a[9:0] + 10'd2];
    b3 = mem[a[9:0] + 10'd3];
    case (fo)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd1:    return {{16{b1[7]}}, b1, b0};
      3'd2:    return {b3, b2, b1, b0};
      3'd4:    return {24'd0, b0};
      3'd5:    return {16'd0, b1, b0};
      default: return 32'd0;
    endcase
  endfunction

  assign mem_data_out = mem_read(mem_address, mem_func_out);

  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_address[9:0]] <= mem_data_in[7:0];
      if (mem_func_in != 2'd0) mem[mem_address[9:0] + 10'd1] <= mem_data_in[15:8];
      if (mem_func_in == 2'd2) begin
        mem[mem_address[9:0] + 10'd2] <= mem_data_in[23:16];
        mem[mem_address[9:0] + 10'd3] <= mem_data_in[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fetch;
    logic        we;
    logic [1:0]  fi;
    logic [2:0]  fo;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [20];

  task automatic run_vec(input int idx, input vec_t v);
    int  n;
    bit  got;
    @(negedge clock);
    if (v.fetch) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      ls_req      = 1'b1;
      ls_we       = v.we;
      ls_func_in  = v.fi;
      ls_func_out = v.fo;
      ls_addr     = v.addr;
      ls_wdata    = v.wdata;
    end
    n   = 0;
    got = 0;
    while (!got && n < 8) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        chk("access_busy", 32'(busy), 32'd1);
        chk("access_mem_we", 32'(mem_we), 32'(v.we && !v.err));
        chk("access_addr", mem_address, v.addr);
      end
      if (if_ack || ls_ack) got = 1;
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      chk("ack_latency", 32'(n), 32'd2);
      chk("resp_busy", 32'(busy), 32'd1);
      chk("if_ack", 32'(if_ack), 32'(v.fetch));
      chk("ls_ack", 32'(ls_ack), 32'(!v.fetch));
      chk("err", 32'(v.fetch ? if_err : ls_err), 32'(v.err));
      chk("rdata", v.fetch ? if_rdata : ls_rdata, v.rdata);
    end
    $display("vec %0d: %s addr=%h err=%b rdata=%h", idx, v.fetch ? "IF" : "LS", v.addr,
             v.fetch ? if_err : ls_err, v.fetch ? if_rdata : ls_rdata);
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, acks, last_n, exp_port;
    bit got;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;
    mem[64] = 8'h11;

    //           fetch we    fi    fo    addr          wdata         err   rdata
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 3'd2, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b1, 2'd2, 3'd0, 32'h20,       32'h12345678, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 3'd4, 32'h21,       32'h0,        1'b0, 32'h00000056};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 3'd2, 32'h20,       32'h0,        1'b0, 32'h12345678};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 3'd0, 32'h13,       32'h0,        1'b0, 32'hFFFFFFDE};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 3'd1, 32'h12,       32'h0,        1'b0, 32'hFFFFDEAD};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 3'd5, 32'h12,       32'h0,        1'b0, 32'h0000DEAD};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 3'd0, 32'h31,       32'h0000BEEF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 2'd0, 3'd2, 32'h30,       32'h0,        1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 3'd2, 32'h3FE,      32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 3'd2, 32'h2,        32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 3'd0, 32'h3FC,      32'hCAFEF00D, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 3'd2, 32'h3FC,      32'h0,        1'b0, 32'hCAFEF00D};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 3'd0, 32'h3FF,      32'h0,        1'b0, 32'hFFFFFFCA};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 3'd1, 32'h3FF,      32'h0,        1'b1, 32'h0};
    vecs[15] = '{1'b0, 1'b0, 2'd0, 3'd2, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 2'd0, 3'd3, 32'h20,       32'h0,        1'b1, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 2'd3, 3'd0, 32'h20,       32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[18] = '{1'b0, 1'b0, 2'd0, 3'd2, 32'h20,       32'h0,        1'b0, 32'h12345678};
    vecs[19] = '{1'b0, 1'b0, 2'd0, 3'd1, 32'h3FE,      32'h0,        1'b0, 32'hFFFFCAFE};

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_func_in = '0; ls_func_out = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_ls_ack", 32'(ls_ack), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'd0);
    chk("rst_mem_func", {27'd0, mem_func_in, mem_func_out}, 32'd0);
    chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_no_req_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);
    @(negedge clock);
    chk("after_vec_busy", 32'(busy), 32'd0);

    // Simultaneous requests held across four accesses.
    do_reset();
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_we = 1'b0; ls_func_out = 3'd2; ls_addr = 32'h20;
    n = 0; acks = 0; last_n = -1;
    while (acks < 4 && n < 30) begin
      @(negedge clock);
      n++;
      if (if_ack && ls_ack) chk("dual_ack", 32'd1, 32'd0);
      if (if_ack || ls_ack) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_port = (acks % 2 == 0) ? 1 : 0;
`else
        exp_port = 1;
`endif
        chk("arb_port", 32'(ls_ack), 32'(exp_port));
        chk("arb_rdata", ls_ack ? ls_rdata : if_rdata, ls_ack ? 32'h12345678 : 32'hDEADBEEF);
        chk("arb_gap", 32'(n - last_n), (acks == 0) ? 32'(n + 1) : 32'd3);
        $display("arb grant %0d: %s at cycle %0d", acks, ls_ack ? "LS" : "IF", n);
        last_n = n;
        acks++;
      end
    end
    if (acks < 4) chk("arb_timeout", 32'(acks), 32'd4);
    if_req = 1'b0;
    ls_req = 1'b0;
    @(negedge clock);

    // Reset during the ACCESS cycle of a store aborts it; the held request then completes.
    @(negedge clock);
    ls_req = 1'b1; ls_we = 1'b1; ls_func_in = 2'd0; ls_addr = 32'h40; ls_wdata = 32'h000000AA;
    @(negedge clock);
    chk("rst_access_mem_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_abort_mem_we", 32'(mem_we), 32'd0);
    chk("rst_abort_busy", 32'(busy), 32'd0);
    @(negedge clock);
    chk("rst_abort_ack", 32'(ls_ack | if_ack), 32'd0);
    chk("rst_abort_byte", 32'(mem[64]), 32'h11);
    reset = 1'b0;
    n = 0; got = 0;
    while (!got && n < 8) begin
      @(negedge clock);
      n++;
      if (ls_ack || if_ack) got = 1;
    end
    if (!got) begin
      chk("rearb_timeout", 32'd0, 32'd1);
    end else begin
      chk("rearb_latency", 32'(n), 32'd2);
      chk("rearb_ls_ack", 32'(ls_ack), 32'd1);
      chk("rearb_err", 32'(ls_err), 32'd0);
      chk("rearb_rdata", ls_rdata, 32'd0);
    end
    $display("rearb store: ack=%b err=%b byte40=%h", ls_ack, ls_err, mem[64]);
    ls_req = 1'b0;
    @(negedge clock);
    chk("rearb_byte", 32'(mem[64]), 32'hAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
